mempool_tcdm_floo_responder: RTL
================================

Name: mempool_tcdm_floo_responder

Overview:
- Target-side endpoint of the FlooNoC TCDM path. Receives request flits from the group router and drives them into one remote TCDM slave port of a tile.
- Returns read responses as response flits addressed back to the originating node.
- Sits between a router's local port and one mempool_group tcdm_slave port pair.
- Complements the initiator-side chimney: requests in, responses out.

Parameters:
- MaxOutstanding, 4, maximum in-flight reads awaiting a TCDM response (≥1, power of 2).
- CntWidth, idx_width(MaxOutstanding+1), derived; width of the outstanding counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- id_i  in  id_t  own XY coordinate; used as src in response flits
- floo_req_i  in  floo_req_flit_t  incoming request flit {hdr.src_id, hdr.dst_id, meta_id, addr, wen, be, data, amo}
- floo_req_valid_i  in  1  request flit valid
- floo_req_ready_o  out  1  request flit accepted
- floo_rsp_o  out  floo_rsp_flit_t  response flit {hdr.src_id, hdr.dst_id, meta_id, data}
- floo_rsp_valid_o  out  1  response flit valid
- floo_rsp_ready_i  in  1  router accepts response
- tcdm_slave_req_o  out  tcdm_slave_req_t  TCDM request toward the tile
- tcdm_slave_req_valid_o  out  1  TCDM request valid
- tcdm_slave_req_ready_i  in  1  TCDM request accepted
- tcdm_slave_resp_i  in  tcdm_slave_resp_t  TCDM read data
- tcdm_slave_resp_valid_i  in  1  TCDM response valid
- tcdm_slave_resp_ready_o  out  1  TCDM response accepted
- busy_o  out  1  outstanding count ≠ 0 or response register full
- err_o  out  1  one-cycle pulse on protocol violation

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous, active-low, on rst_ni. On reset, all outputs are 0 and floo_rsp_o is '0.
- Request path is combinational, 0 cycles:
  - tcdm_slave_req_o is mapped field by field from floo_req_i.
  - tcdm_slave_req_valid_o = floo_req_valid_i & can_issue.
  - floo_req_ready_o = tcdm_slave_req_ready_i & can_issue.
  - can_issue = wen | ~full.
- Writes and AMOs with wen=1 produce no response and allocate nothing. Reads and AMOs with wen=0 allocate.
- Tracker:
  - In-order FIFO of depth MaxOutstanding holding {hdr.src_id, meta_id}. Push on a read handshake; pop on a TCDM response handshake.
  - full is evaluated on registered occupancy. A pop in the same cycle does not unblock a push when full.
  - Push and pop in the same cycle when not full keep occupancy unchanged.
  - Pointers wrap modulo MaxOutstanding.
- Response path has 1-cycle latency through a single output register:
  - tcdm_slave_resp_ready_o = ~rsp_valid_q | floo_rsp_ready_i.
  - On a response handshake, register hdr.dst_id = FIFO head src_id, hdr.src_id = id_i, meta_id = head meta_id, data = tcdm_slave_resp_i.data.
  - Full throughput of one response per cycle with back-to-back readiness.
  - floo_rsp_o and floo_rsp_valid_o stay stable while floo_rsp_ready_i=0. No combinational path from floo_rsp_ready_i to floo_rsp_valid_o.
- Error: a TCDM response while the tracker is empty is accepted and dropped, and err_o pulses for 1 cycle. The FIFO stays empty and no flit is emitted.
- Reset mid-operation clears the FIFO, counter and response register. In-flight transactions are lost; the system resets both ends together.
- floo_req_valid_i may be held without ready. The block never drops a request that has not been handshaken.

Decomposition:
- mempool_pkg (shared) holds tcdm_slave_req_t and tcdm_slave_resp_t, the floo flit typedefs, id_t and meta_id_t.
- The tracker uses the common_cells fifo_v3 (FALL_THROUGH=0, DEPTH=MaxOutstanding).
- One natural sub-module is mempool_floo_rsp_reg, the response output register with its handshake, reusable by the initiator chimney.
- Flit↔TCDM field mapping functions go in mempool_pkg.

Test Plan:
- Single read: id_i=(1,2); req src=(3,0), meta=5, addr=0x40, wen=0; TCDM resp data 0xDEADBEEF at cycle t → floo_rsp_valid_o at t+1 with dst=(3,0), src=(1,2), meta=5, data=0xDEADBEEF.
- Fill: 4 reads, TCDM withholds responses → 5th read sees floo_req_ready_o=0. A write (wen=1) in the same state passes (ready=1). After one response pops, the 5th read is accepted one cycle later.
- Ordering: reads meta 1,2,3 from src (0,0),(2,1),(3,3) → responses emitted in order with matching dst/meta.
- Backpressure: floo_rsp_ready_i=0 for 5 cycles with 2 responses pending → tcdm_slave_resp_ready_o=0 after the first. The flit is held stable; both flits are delivered after release, none lost.
- Spurious response: TCDM resp_valid with the tracker empty → err_o=1 for exactly 1 cycle, no flit, busy_o=0.
- Reset mid-flight: 3 reads outstanding, rst_ni=0 for 1 cycle → busy_o=0, floo_rsp_valid_o=0, and a new read is accepted immediately.

Source files
------------

// File: rtl/mempool_tcdm_floo_responder_pkg.sv
// Shared types for the TCDM FlooNoC responder: flit formats, TCDM slave port types and
// the flit <-> TCDM field mapping helpers.
package mempool_tcdm_floo_responder_pkg;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } id_t;

    typedef logic [3:0]  meta_id_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  be_t;
    typedef logic [3:0]  amo_t;

    typedef struct packed {
        id_t src_id;
        id_t dst_id;
    } floo_hdr_t;

    typedef struct packed {
        floo_hdr_t hdr;
        meta_id_t  meta_id;
        addr_t     addr;
        logic      wen;
        be_t       be;
        data_t     data;
        amo_t      amo;
    } floo_req_flit_t;

    typedef struct packed {
        floo_hdr_t hdr;
        meta_id_t  meta_id;
        data_t     data;
    } floo_rsp_flit_t;

    typedef struct packed {
        addr_t addr;
        logic  wen;
        be_t   be;
        data_t data;
        amo_t  amo;
    } tcdm_slave_req_t;

    typedef struct packed {
        data_t data;
    } tcdm_slave_resp_t;

    typedef struct packed {
        id_t      src_id;
        meta_id_t meta_id;
    } tracker_entry_t;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? $clog2(num_idx) : 32'd1;
    endfunction

    function automatic tcdm_slave_req_t floo_to_tcdm_req(input floo_req_flit_t flit);
        tcdm_slave_req_t req;
        req.addr = flit.addr;
        req.wen  = flit.wen;
        req.be   = flit.be;
        req.data = flit.data;
        req.amo  = flit.amo;
        return req;
    endfunction

    // Response goes back to whoever issued the request, tagged with our own coordinate.
    function automatic floo_rsp_flit_t tcdm_to_floo_rsp(input tcdm_slave_resp_t resp,
                                                        input id_t own_id,
                                                        input tracker_entry_t entry);
        floo_rsp_flit_t rsp;
        rsp.hdr.src_id = own_id;
        rsp.hdr.dst_id = entry.src_id;
        rsp.meta_id    = entry.meta_id;
        rsp.data       = resp.data;
        return rsp;
    endfunction

endpackage

// File: rtl/mempool_tcdm_floo_responder_if.sv
// Handshake bundle between the router local port, the responder and one TCDM slave port.
// master = router/tile side, slave = responder side.
interface mempool_tcdm_floo_responder_if;
    import mempool_tcdm_floo_responder_pkg::*;

    floo_req_flit_t   floo_req;
    logic             floo_req_valid;
    logic             floo_req_ready;
    floo_rsp_flit_t   floo_rsp;
    logic             floo_rsp_valid;
    logic             floo_rsp_ready;
    tcdm_slave_req_t  tcdm_slave_req;
    logic             tcdm_slave_req_valid;
    logic             tcdm_slave_req_ready;
    tcdm_slave_resp_t tcdm_slave_resp;
    logic             tcdm_slave_resp_valid;
    logic             tcdm_slave_resp_ready;

    modport master (
        output floo_req, floo_req_valid, floo_rsp_ready,
        output tcdm_slave_req_ready, tcdm_slave_resp, tcdm_slave_resp_valid,
        input  floo_req_ready, floo_rsp, floo_rsp_valid,
        input  tcdm_slave_req, tcdm_slave_req_valid, tcdm_slave_resp_ready
    );

    modport slave (
        input  floo_req, floo_req_valid, floo_rsp_ready,
        input  tcdm_slave_req_ready, tcdm_slave_resp, tcdm_slave_resp_valid,
        output floo_req_ready, floo_rsp, floo_rsp_valid,
        output tcdm_slave_req, tcdm_slave_req_valid, tcdm_slave_resp_ready
    );

endinterface

// File: rtl/mempool_tcdm_floo_responder_rsp_reg.sv
// Single-entry response flit output register; accepts a new flit whenever it is empty or
// being drained in the same cycle, so back-to-back traffic flows at one flit per cycle.
module mempool_tcdm_floo_responder_rsp_reg
    import mempool_tcdm_floo_responder_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  floo_rsp_flit_t in_data_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    output floo_rsp_flit_t out_data_o,
    output logic           out_valid_o,
    input  logic           out_ready_i
);

    floo_rsp_flit_t data_q, data_d;
    logic           valid_q, valid_d;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mempool_tcdm_floo_responder.sv
// Target-side FlooNoC endpoint for one TCDM slave port: forwards request flits to the tile and
// returns read data as response flits to the originating node, in request order.
module mempool_tcdm_floo_responder
    import mempool_tcdm_floo_responder_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = idx_width(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  id_t                                 id_i,
    mempool_tcdm_floo_responder_if.slave        bus,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int unsigned PtrWidth = idx_width(MaxOutstanding);

    tracker_entry_t        mem_q [MaxOutstanding];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  full, empty, can_issue, push, pop, rsp_hs, rsp_valid, rsp_ready;
    tracker_entry_t        push_entry;
    floo_rsp_flit_t        rsp_flit;

    // Occupancy is registered, so a pop in the same cycle never frees a slot for a push.
    assign full      = (cnt_q == CntWidth'(MaxOutstanding));
    assign empty     = (cnt_q == '0);
    assign can_issue = bus.floo_req.wen | ~full;

    assign bus.tcdm_slave_req       = floo_to_tcdm_req(bus.floo_req);
    assign bus.tcdm_slave_req_valid = bus.floo_req_valid & can_issue;
    assign bus.floo_req_ready       = bus.tcdm_slave_req_ready & can_issue;

    assign push   = bus.floo_req_valid & bus.floo_req_ready & ~bus.floo_req.wen;
    assign rsp_hs = bus.tcdm_slave_resp_valid & bus.tcdm_slave_resp_ready;
    assign pop    = rsp_hs & ~empty;
    // A response with nothing tracked has no destination: swallow it and flag it.
    assign err_d  = rsp_hs & empty;

    assign push_entry.src_id  = bus.floo_req.hdr.src_id;
    assign push_entry.meta_id = bus.floo_req.meta_id;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CntWidth'(push) - CntWidth'(pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign rsp_flit  = tcdm_to_floo_rsp(bus.tcdm_slave_resp, id_i, mem_q[rd_ptr_q]);
    assign rsp_valid = pop;
    assign bus.tcdm_slave_resp_ready = rsp_ready;

    mempool_tcdm_floo_responder_rsp_reg i_rsp_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (rsp_flit),
        .in_valid_i  (rsp_valid),
        .in_ready_o  (rsp_ready),
        .out_data_o  (bus.floo_rsp),
        .out_valid_o (bus.floo_rsp_valid),
        .out_ready_i (bus.floo_rsp_ready)
    );

    assign busy_o = ~empty | bus.floo_rsp_valid;
    assign err_o  = err_q;

endmodule
